rr_grant_arbiter: RTL and testbench
===================================

# rr_grant_arbiter

Round-robin arbiter for N requesters, built around a first-one (lowest-set-bit) priority search on a rotated request vector. It sits directly downstream of the first-one finder: the finder's one-hot selection becomes a registered, held grant with a release handshake and a hold-time watchdog. Consumers see a stable one-hot `gnt` plus its binary index for the full duration of each ownership window.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; 0 disables the watchdog.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  N  request vector, level-sensitive; bit i is requester i.
- `done`  in  1  owner releases the grant; sampled only in GRANT.
- `gnt`  out  N  registered one-hot grant; all zero when idle.
- `gnt_vld`  out  1  high exactly when `gnt` ≠ 0.
- `gnt_idx`  out  $clog2(N)  binary index of the granted bit; holds its last value when idle.
- `timeout`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- Reset values (rst_n = 0 at an edge): `gnt` = 0, `gnt_vld` = 0, `gnt_idx` = 0, `timeout` = 0, pointer `ptr` = 0, `hold_cnt` = 0, state IDLE.
- States: IDLE and GRANT.
- **IDLE:**
  - Form `masked = req & ~((1<<ptr)-1)`.
  - Winner is the lowest set bit of `masked` if `masked` ≠ 0, otherwise the lowest set bit of `req`.
  - If `req` ≠ 0, the next edge loads `gnt` with the winner one-hot, `gnt_idx` with its index, clears `hold_cnt`, and moves to GRANT.
  - If `req` = 0, remain in IDLE.
- **GRANT:**
  - `gnt` and `gnt_idx` hold. Changes on non-granted `req` bits are ignored.
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`.
  - Release condition is any of:
    - (a) `done` = 1;
    - (b) `req[gnt_idx]` = 0;
    - (c) `MAX_HOLD` ≠ 0 and `hold_cnt` == `MAX_HOLD-1`.
  - On release, the next edge clears `gnt`/`gnt_vld`, sets `ptr = (gnt_idx+1) mod N` (index N-1 wraps to 0), and moves to IDLE.
- `timeout` is asserted on the release edge only when (c) holds and neither (a) nor (b) holds. If `done` and the watchdog fire together, `done` wins and no timeout is reported.
- `ptr` updates only on release, never in IDLE.
- With a single requester, that requester is re-granted after each idle bubble.
- Invariant: `gnt` is zero or exactly one-hot, always.

## Timing
- Request to grant:
  - `req` sampled high in IDLE at edge k gives `gnt_vld` = 1 from edge k onward.
  - Visible one cycle after `req` is presented with the state in IDLE.
- Release:
  - `done`, req drop, or watchdog sampled at edge m gives `gnt_vld` = 0 after edge m.
  - `timeout` is high for the single cycle following edge m, coincident with `gnt` = 0.
- A minimum of one IDLE cycle separates consecutive grants. Re-arbitration happens at the edge after the release edge.
- Watchdog: with no `done` and `req` held, `gnt_vld` is high for exactly `MAX_HOLD` cycles.
- Reset mid-GRANT: `rst_n` = 0 at any edge returns all outputs and `ptr` to their reset values at that edge, and aborts any pending timeout.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** `req` = 1111 with `rst_n` low for 2 edges → `gnt` = 0000, `timeout` = 0 throughout. First edge after `rst_n` rises → `gnt` = 0001, `gnt_idx` = 0.
- **Rotation:** `req` = 1111 held, `done` pulsed 3 cycles into each grant → grant sequence 0001, 0010, 0100, 1000, 0001, each followed by exactly one `gnt` = 0000 cycle.
- **Wrap search:** grant 0010 released (`ptr` = 2), then `req` = 0011 → `gnt` = 0001, `gnt_idx` = 0. Then `req` = 1001 after release (`ptr` = 1) → `gnt` = 1000.
- **Watchdog:** `MAX_HOLD` = 16, `req` = 0100, `done` = 0 → `gnt_vld` high for exactly 16 cycles, then `timeout` = 1 for 1 cycle with `gnt` = 0000. Repeat with `done` = 1 on cycle 16 → `timeout` stays 0.
- **Requester drop:** `req` = 0010 granted, `req[1]` deasserted on cycle 4 → `gnt` = 0000 at the next edge, `timeout` = 0, next grant search starts at index 2.
- **Reset mid-grant:** `rst_n` low for one edge while `gnt` = 1000 → `gnt` = 0000 and `gnt_idx` = 0 immediately after that edge. With `req` = 1111 afterwards → `gnt` = 0001 (`ptr` reset to 0).

Source files
------------

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle for the round-robin grant arbiter.
// The master side drives requests and releases; the slave side (the arbiter) returns the grant.
interface rr_grant_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;
    logic            timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_vld,
        input  gnt_idx,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_vld,
        output gnt_idx,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: a first-one search over the requests at or above the rotating
// pointer (falling back to all requests) picks the winner, which then owns a registered,
// held one-hot grant until it signals done, drops its request, or the hold watchdog expires.
module rr_grant_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rr_grant_arbiter_if.slave   bus_io
);
    localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    // Saturation value of the hold counter; with the watchdog disabled it parks at zero.
    localparam int unsigned CntMax = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    masked;
    logic [IdxW-1:0] win_idx;
    logic            owner_req;
    logic            wd_fire;
    logic            release_gnt;

    // Index of the lowest set bit of v; zero when v is empty (callers qualify with |v).
    function automatic logic [IdxW-1:0] first_one(input logic [N-1:0] v);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IdxW'(i);
            end
        end
        return idx;
    endfunction

    // Winner search: lowest request at or above the pointer, else lowest request overall.
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked[i] = bus_io.req[i] && (i >= int'(ptr_q));
        end
        win_idx = (|masked) ? first_one(masked) : first_one(bus_io.req);
    end

    // Release qualifiers for the current owner.
    always_comb begin
        owner_req   = bus_io.req[gnt_idx_q];
        wd_fire     = (MAX_HOLD != 0) && (hold_cnt_q == CntW'(CntMax));
        release_gnt = bus_io.done || !owner_req || wd_fire;
    end

    // Next-state logic for the IDLE/GRANT controller and its datapath registers.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|bus_io.req) begin
                    state_d    = StGrant;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                if (hold_cnt_q != CntW'(CntMax)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (release_gnt) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    ptr_d     = (gnt_idx_q == IdxW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
                    // Only a pure watchdog release is reported; done or a dropped request wins.
                    timeout_d = wd_fire && !bus_io.done && owner_req;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_io.gnt     = gnt_q;
    assign bus_io.gnt_vld = |gnt_q;
    assign bus_io.gnt_idx = gnt_idx_q;
    assign bus_io.timeout = timeout_q;

    // The grant is never more than one-hot, and a timeout pulse only coincides with no grant.
    a_gnt_onehot0: assert property (@(posedge clk_i) $onehot0(gnt_q));
    a_timeout_idle: assert property (@(posedge clk_i) timeout_q |-> (gnt_q == '0));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: a directed vector table, hand-written watchdog sequences and a
// randomized phase checked against a rotating-search reference model.
module tb_rr_grant_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned MaxHold = 16;

    logic clk;
    logic rst_n;

    rr_grant_arbiter_if #(.N(N)) bus ();

    rr_grant_arbiter #(
        .N        (N),
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner (-1 when idle), pointer, cycles owned so far, last index, timeout.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;
    int m_idx   = 0;
    bit m_to    = 1'b0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic d,
                                input logic [3:0] g, input logic [1:0] i, input logic t);
        vec_t v;
        v.rst_n = r; v.req = q; v.done = d; v.gnt = g; v.idx = i; v.to = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input bit r, input logic [3:0] q, input bit d);
        bit rel_wd;
        bit rel_drop;
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_idx = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % int'(N)]) begin
                    m_owner = (m_ptr + k) % int'(N);
                end
            end
            if (m_owner >= 0) begin
                m_idx = m_owner;
                m_age = 1;
            end
        end else begin
            rel_drop = !q[m_owner];
            rel_wd   = (MaxHold != 0) && (m_age >= int'(MaxHold));
            if (d || rel_drop || rel_wd) begin
                m_to    = rel_wd && !d && !rel_drop;
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end else begin
                m_to  = 1'b0;
                m_age = m_age + 1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step(rst_n, bus.req, bus.done);
        #1;
        check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic d);
        rst_n    = r;
        bus.req  = q;
        bus.done = d;
    endtask

    int cnt;

    initial begin
        drive(1'b0, 4'h0, 1'b0);

        // reset, rotation, wrap search, requester drop, reset mid-grant
        add(0, 4'hF, 0, 4'h0, 0, 0);
        add(0, 4'hF, 0, 4'h0, 0, 0);
        add(1, 4'hF, 0, 4'h1, 0, 0);
        add(1, 4'hF, 0, 4'h1, 0, 0);
        add(1, 4'hF, 0, 4'h1, 0, 0);
        add(1, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'hF, 0, 4'h2, 1, 0);
        add(1, 4'hF, 0, 4'h2, 1, 0);
        add(1, 4'hF, 0, 4'h2, 1, 0);
        add(1, 4'hF, 1, 4'h0, 1, 0);
        add(1, 4'hF, 0, 4'h4, 2, 0);
        add(1, 4'hF, 0, 4'h4, 2, 0);
        add(1, 4'hF, 0, 4'h4, 2, 0);
        add(1, 4'hF, 1, 4'h0, 2, 0);
        add(1, 4'hF, 0, 4'h8, 3, 0);
        add(1, 4'hF, 0, 4'h8, 3, 0);
        add(1, 4'hF, 0, 4'h8, 3, 0);
        add(1, 4'hF, 1, 4'h0, 3, 0);
        add(1, 4'hF, 0, 4'h1, 0, 0);
        add(1, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'h2, 0, 4'h2, 1, 0);
        add(1, 4'h2, 1, 4'h0, 1, 0);
        add(1, 4'h3, 0, 4'h1, 0, 0);
        add(1, 4'h9, 1, 4'h0, 0, 0);
        add(1, 4'h9, 0, 4'h8, 3, 0);
        add(1, 4'h2, 1, 4'h0, 3, 0);
        add(1, 4'h2, 0, 4'h2, 1, 0);
        add(1, 4'h2, 0, 4'h2, 1, 0);
        add(1, 4'h2, 0, 4'h2, 1, 0);
        add(1, 4'h0, 0, 4'h0, 1, 0);
        add(1, 4'hF, 0, 4'h4, 2, 0);
        add(1, 4'hF, 1, 4'h0, 2, 0);
        add(1, 4'hF, 0, 4'h8, 3, 0);
        add(0, 4'hF, 0, 4'h0, 0, 0);
        add(1, 4'hF, 0, 4'h1, 0, 0);
        add(1, 4'hF, 1, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].done);
            step();
            check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d gnt_idx", i), 32'(bus.gnt_idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d timeout", i), 32'(bus.timeout), 32'(vecs[i].to));
        end

        // Watchdog: held request, no done -> exactly MaxHold cycles of grant, then a timeout pulse
        drive(1'b0, 4'h0, 1'b0);
        step();
        drive(1'b1, 4'h4, 1'b0);
        step();
        cnt = 0;
        while (bus.gnt_vld && cnt < 40) begin
            cnt++;
            step();
        end
        check("wd hold cycles", 32'(cnt), 32'(MaxHold));
        check("wd timeout", 32'(bus.timeout), 32'd1);
        check("wd gnt cleared", 32'(bus.gnt), 32'h0);
        step();
        check("wd timeout one cycle", 32'(bus.timeout), 32'd0);
        check("wd regrant", 32'(bus.gnt), 32'h4);

        // done on the watchdog cycle wins, no timeout
        for (int i = 2; i <= int'(MaxHold); i++) step();
        check("wd cycle16 gnt", 32'(bus.gnt), 32'h4);
        bus.done = 1'b1;
        step();
        check("wd+done gnt", 32'(bus.gnt), 32'h0);
        check("wd+done timeout", 32'(bus.timeout), 32'd0);
        bus.done = 1'b0;

        // Randomized phase against the reference model
        drive(1'b0, 4'h0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 11) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
            check($sformatf("rnd%0d gnt", c), 32'(bus.gnt),
                  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check($sformatf("rnd%0d gnt_vld", c), 32'(bus.gnt_vld), 32'(m_owner >= 0));
            check($sformatf("rnd%0d gnt_idx", c), 32'(bus.gnt_idx), 32'(m_idx));
            check($sformatf("rnd%0d timeout", c), 32'(bus.timeout), 32'(m_to));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
